thermo_peak_ctrl: RTL and testbench

Peak-hold/decay sequencer that drives a thermometer (bar-graph) encoder. It accepts level samples over a valid/ready handshake and tracks the running peak. It holds the peak for a fixed number of cycles, then decays it one step at a time. It outputs both the K-bit level code and the registered W-bit thermometer bar, and sits between a sample source (ADC/meter logic) and the LED bar driver.

---
 rtl/thermo_peak_ctrl.sv | 89 ++++++++
 tb/tb_thermo_peak_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thermo_peak_ctrl.sv
// thermo_peak_ctrl: peak-hold/decay level sequencer with a registered thermometer bar.
// Define PEAK_DOT_EN to add dot_mode (single-dot bar instead of filled bar).
module thermo_peak_ctrl #(
  parameter int K         = 3,
  parameter int W         = 7,
  parameter int HOLD_CYC  = 8,
  parameter int DECAY_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
`ifdef PEAK_DOT_EN
  input  logic         dot_mode,
`endif
  input  logic         in_valid,
  input  logic [K-1:0] in_level,
  output logic         in_ready,
  output logic [K-1:0] level,
  output logic [W-1:0] bar,
  output logic [1:0]   state
);
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  localparam int DW = DECAY_CYC > 1 ? $clog2(DECAY_CYC) : 1;
  localparam logic [K-1:0] WMAX = K'(W);
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, DECAY = 2'd2} state_t;
  state_t        state_q, state_d;
  logic [K-1:0]  level_q, level_d, s;
  logic [W-1:0]  bar_q, bar_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] decay_q, decay_d;
  logic          cap, dot;
  assign in_ready = ~rst;
  assign s        = in_level > WMAX ? WMAX : in_level;
  // equal peaks also capture so the hold restarts
  assign cap      = in_valid && in_ready && s >= level_q && s != '0;
`ifdef PEAK_DOT_EN
  assign dot = dot_mode;
`else
  assign dot = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    decay_d = decay_q;
    if (cap) begin
      state_d = HOLD;
      level_d = s;
      hold_d  = HW'(HOLD_CYC - 1);
    end else if (state_q == HOLD) begin
      if (hold_q == '0) begin
        state_d = DECAY;
        decay_d = DW'(DECAY_CYC - 1);
      end else begin
        hold_d = hold_q - HW'(1);
      end
    end else if (state_q == DECAY) begin
      if (decay_q != '0) begin
        decay_d = decay_q - DW'(1);
      end else begin
        decay_d = DW'(DECAY_CYC - 1);
        level_d = level_q == '0 ? '0 : level_q - K'(1);
        state_d = level_q <= K'(1) ? IDLE : DECAY;
      end
    end
  end
  always_comb begin
    bar_d = '0;
    for (int i = 0; i < W; i++)
      bar_d[i] = dot ? (32'(level_d) == i + 1) : (32'(level_d) > i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      bar_q   <= '0;
      hold_q  <= '0;
      decay_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      bar_q   <= bar_d;
      hold_q  <= hold_d;
      decay_q <= decay_d;
    end
  end
  assign level = level_q;
  assign bar   = bar_q;
  assign state = state_q;
endmodule

// File: tb/tb_thermo_peak_ctrl.sv
// tb_thermo_peak_ctrl: randomized and directed checks of thermo_peak_ctrl against a
// time-since-capture reference model.
module tb_thermo_peak_ctrl;
  localparam int W    = 7;
  localparam int HOLD = 8;
  localparam int DEC  = 4;
  logic       clk, rst;
  logic       in_valid;
  logic [2:0] in_level;
  logic       in_ready;
  logic [2:0] level;
  logic [6:0] bar;
  logic [1:0] state;
  logic       c_valid;
  logic [2:0] c_level;
  logic       c_ready;
  logic [2:0] c_lvl;
  logic [4:0] c_bar;
  logic [1:0] c_state;
`ifdef PEAK_DOT_EN
  logic       dot_mode;
`endif
  int vecs, errs;
  int t, cap_time, cap_level;

  thermo_peak_ctrl #(.K(3), .W(W), .HOLD_CYC(HOLD), .DECAY_CYC(DEC)) u_dut (
    .clk(clk), .rst(rst),
`ifdef PEAK_DOT_EN
    .dot_mode(dot_mode),
`endif
    .in_valid(in_valid), .in_level(in_level), .in_ready(in_ready),
    .level(level), .bar(bar), .state(state)
  );

  thermo_peak_ctrl #(.K(3), .W(5), .HOLD_CYC(HOLD), .DECAY_CYC(DEC)) u_clamp (
    .clk(clk), .rst(rst),
`ifdef PEAK_DOT_EN
    .dot_mode(1'b0),
`endif
    .in_valid(c_valid), .in_level(c_level), .in_ready(c_ready),
    .level(c_lvl), .bar(c_bar), .state(c_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // displayed level is a pure function of the last capture and elapsed edges
  function automatic int mlev(input int tt);
    int e, st;
    if (cap_level == 0) return 0;
    e = tt - cap_time;
    if (e < HOLD) return cap_level;
    st = (e - HOLD) / DEC;
    return cap_level > st ? cap_level - st : 0;
  endfunction

  function automatic int mst(input int tt);
    if (mlev(tt) == 0) return 0;
    return (tt - cap_time < HOLD) ? 1 : 2;
  endfunction

  function automatic logic [6:0] ebar(input int l);
    return 7'((1 << l) - 1);
  endfunction

  task automatic step(input logic v, input logic [2:0] lv);
    int s, cur;
    in_valid = v;
    in_level = lv;
    cur = mlev(t);
    s = (int'(lv) > W) ? W : int'(lv);
    @(posedge clk);
    #1;
    t++;
    if (v && s >= cur && s != 0) begin
      cap_time  = t;
      cap_level = s;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    #2 rst = 1'b0;
    cap_level = 0;
  endtask

  task automatic test_reset();
    vecs++;
    if ({level, bar, state, in_ready} !== {3'd0, 7'd0, 2'd0, 1'b0}) begin
      errs++;
      $display("FAIL reset_init got lvl=%0d bar=%b st=%0d rdy=%b exp 0/0/0/0", level, bar, state, in_ready);
    end
    #10 rst = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_after_reset got %b exp 1", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 3'd5);
    for (int k = 1; k <= 9; k++) step(1'b0, 3'd0);
    vecs++;
    if ({level, state} !== {3'd5, 2'd2}) begin
      errs++;
      $display("FAIL pre_reset got lvl=%0d st=%0d exp 5/2", level, state);
    end
    #3 rst = 1'b1;
    #1;
    vecs++;
    if ({level, bar, state, in_ready} !== {3'd0, 7'd0, 2'd0, 1'b0}) begin
      errs++;
      $display("FAIL reset_mid got lvl=%0d bar=%b st=%0d rdy=%b exp 0/0/0/0", level, bar, state, in_ready);
    end
    in_valid = 1'b1;
    in_level = 3'd6;
    @(posedge clk);
    #1;
    vecs++;
    if ({level, state} !== {3'd0, 2'd0}) begin
      errs++;
      $display("FAIL reset_drop got lvl=%0d st=%0d exp 0/0", level, state);
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    cap_level = 0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_release got %b exp 1", in_ready);
    end
  endtask

  task automatic test_capture_hold_decay();
    do_reset();
    step(1'b1, 3'd5);
    vecs++;
    if ({level, bar, state} !== {3'd5, 7'b0011111, 2'd1}) begin
      errs++;
      $display("FAIL capture got lvl=%0d bar=%b st=%0d exp 5/0011111/1", level, bar, state);
    end
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 3'd0);
      vecs++;
      if ({level, bar, state} !== {3'(mlev(t)), ebar(mlev(t)), 2'(mst(t))}) begin
        errs++;
        $display("FAIL decay_seq edge=%0d got lvl=%0d bar=%b st=%0d exp %0d/%b/%0d", k, level, bar, state, mlev(t), ebar(mlev(t)), mst(t));
      end
      if (k == 7 || k == 8 || k == 11 || k == 12 || k == 27 || k == 28) begin
        vecs++;
        if ({level, state} !== (k == 7 ? {3'd5, 2'd1} : k == 8 ? {3'd5, 2'd2} : k == 11 ? {3'd5, 2'd2} :
                                k == 12 ? {3'd4, 2'd2} : k == 27 ? {3'd1, 2'd2} : {3'd0, 2'd0})) begin
          errs++;
          $display("FAIL decay_mark edge=%0d got lvl=%0d st=%0d", k, level, state);
        end
      end
    end
  endtask

  task automatic test_lower_zero();
    do_reset();
    step(1'b1, 3'd5);
    step(1'b1, 3'd3);
    step(1'b1, 3'd0);
    vecs++;
    if ({level, state} !== {3'd5, 2'd1}) begin
      errs++;
      $display("FAIL lower_zero got lvl=%0d st=%0d exp 5/1", level, state);
    end
    for (int k = 3; k <= 8; k++) step(1'b0, 3'd0);
    vecs++;
    if ({level, state} !== {3'd5, 2'd2}) begin
      errs++;
      $display("FAIL lower_zero_hold got lvl=%0d st=%0d exp 5/2", level, state);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 3'd5);
    for (int k = 1; k <= 7; k++) step(1'b0, 3'd0);
    step(1'b1, 3'd6);
    vecs++;
    if ({level, bar, state} !== {3'd6, 7'b0111111, 2'd1}) begin
      errs++;
      $display("FAIL simult got lvl=%0d bar=%b st=%0d exp 6/0111111/1", level, bar, state);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 3'd0);
      vecs++;
      if (state !== (k < 8 ? 2'd1 : 2'd2)) begin
        errs++;
        $display("FAIL simult_hold k=%0d got st=%0d exp %0d", k, state, k < 8 ? 1 : 2);
      end
    end
  endtask

  task automatic test_clamp();
    c_valid = 1'b1;
    c_level = 3'd7;
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    vecs++;
    if ({c_lvl, c_bar, c_state} !== {3'd5, 5'b11111, 2'd1}) begin
      errs++;
      $display("FAIL clamp got lvl=%0d bar=%b st=%0d exp 5/11111/1", c_lvl, c_bar, c_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [6] = '{3'd2, 3'd4, 3'd4, 3'd6, 3'd3, 3'd7};
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k < 6) step(1'b1, seq[k]);
      else step(1'b0, 3'd0);
      vecs++;
      if ({level, bar, state} !== {3'(mlev(t)), ebar(mlev(t)), 2'(mst(t))}) begin
        errs++;
        $display("FAIL b2b k=%0d got lvl=%0d bar=%b st=%0d exp %0d/%b/%0d", k, level, bar, state, mlev(t), ebar(mlev(t)), mst(t));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 11) == 0), 3'($urandom_range(0, 7)));
      vecs++;
      if ({level, bar, state, in_ready} !== {3'(mlev(t)), ebar(mlev(t)), 2'(mst(t)), 1'b1}) begin
        errs++;
        $display("FAIL random k=%0d got lvl=%0d bar=%b st=%0d exp %0d/%b/%0d", k, level, bar, state, mlev(t), ebar(mlev(t)), mst(t));
      end
    end
  endtask

`ifdef PEAK_DOT_EN
  task automatic test_dot();
    do_reset();
    step(1'b1, 3'd4);
    dot_mode = 1'b1;
    step(1'b0, 3'd0);
    vecs++;
    if (bar !== 7'b0001000) begin
      errs++;
      $display("FAIL dot got bar=%b exp 0001000", bar);
    end
    dot_mode = 1'b0;
    step(1'b0, 3'd0);
    vecs++;
    if (bar !== 7'b0001111) begin
      errs++;
      $display("FAIL dot_off got bar=%b exp 0001111", bar);
    end
  endtask
`endif

  initial begin
    vecs = 0;
    errs = 0;
    t = 0;
    cap_time = 0;
    cap_level = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_level = 3'd0;
    c_valid = 1'b0;
    c_level = 3'd0;
`ifdef PEAK_DOT_EN
    dot_mode = 1'b0;
`endif
    #2;
    test_reset();
    test_capture_hold_decay();
    test_lower_zero();
    test_simultaneous();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
`ifdef PEAK_DOT_EN
    test_dot();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
